// File: rtl/pls_cnt_mod.sv
// Parametrised modulo-MOD pulse counter with synchronised pulse/clear inputs,
// synchronous load, up/down counting, a duty-threshold output and a wrap carry.
// Stages cascade by feeding carry or plso into the next stage's plsi.
module pls_cnt_mod #(
    parameter int MOD  = 100,
    parameter int W    = 7,
    parameter int EDGE = 0,
    parameter int DUTY = 50
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         plsi,
    input  logic         en,
    input  logic         dir,
    input  logic         ld,
    input  logic [W-1:0] ld_val,
    output logic [W-1:0] qout,
    output logic         plso,
    output logic         carry
);

    localparam logic [W-1:0] MAXV  = W'(MOD - 1);
    localparam logic [W-1:0] DUTYV = W'(DUTY);

    logic         cl0;
    logic         cl1;
    logic         pl0;
    logic         pl1;
    logic         clr_edge;
    logic         pls_edge;
    logic [W-1:0] q_nxt;
    logic         carry_nxt;

    assign clr_edge = cl0 & ~cl1;
    assign pls_edge = (EDGE == 0) ? (pl1 & ~pl0) : (~pl1 & pl0);

    // Two-flop samplers; a clear reloads the pulse pair with plsi so no stale edge survives it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cl0 <= 1'b0;
            cl1 <= 1'b0;
            pl0 <= 1'b0;
            pl1 <= 1'b0;
        end else begin
            cl0 <= clr;
            cl1 <= cl0;
            if (clr_edge) begin
                pl0 <= plsi;
                pl1 <= plsi;
            end else begin
                pl0 <= plsi;
                pl1 <= pl0;
            end
        end
    end

    // Next count and wrap flag: clear beats load, load beats a counted edge
    always_comb begin
        q_nxt     = qout;
        carry_nxt = 1'b0;
        if (clr_edge) begin
            q_nxt = '0;
        end else if (ld) begin
            q_nxt = (ld_val > MAXV) ? MAXV : ld_val;
        end else if (pls_edge && en) begin
            if (!dir) begin
                if (qout >= MAXV) begin
                    q_nxt     = '0;
                    carry_nxt = 1'b1;
                end else begin
                    q_nxt = qout + 1'b1;
                end
            end else begin
                if (qout == '0) begin
                    q_nxt     = MAXV;
                    carry_nxt = 1'b1;
                end else begin
                    q_nxt = qout - 1'b1;
                end
            end
        end
    end

    // Output registers; plso is derived from the next count so it always matches qout
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            qout  <= '0;
            plso  <= 1'b0;
            carry <= 1'b0;
        end else begin
            qout  <= q_nxt;
            plso  <= (q_nxt >= DUTYV);
            carry <= carry_nxt;
        end
    end

endmodule
